shift_8_multi_read: RTL and testbench



---
 rtl/shift_8_multi_read.sv | 76 +++++++
 tb/tb_shift_8_multi_read.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/shift_8_multi_read.sv
// ============================================================================
// Module   : shift_8_multi_read
// Brief    : 8-stage word shift register with one addressed read port and
//            fixed taps p2..p7. Macro SHIFT8_RD_REG_EN registers rd_data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_8_multi_read #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  p2,
  output logic [WIDTH-1:0]  p3,
  output logic [WIDTH-1:0]  p4,
  output logic [WIDTH-1:0]  p5,
  output logic [WIDTH-1:0]  p6,
  output logic [WIDTH-1:0]  p7
);

  localparam int c_IDX_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic             w_in_range;
  logic [WIDTH-1:0] w_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write_en) begin
      r_mem[0] <= wr_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  // Out-of-range addresses read as zero rather than aliasing onto a stage.
  assign w_in_range = (addr < ADDR_W'(DEPTH));
  assign w_rd_data  = w_in_range ? r_mem[addr[c_IDX_W-1:0]] : '0;

`ifdef SHIFT8_RD_REG_EN
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= w_rd_data;
    end
  end

  assign rd_data = r_rd_data;
`else
  assign rd_data = w_rd_data;
`endif

  assign p2 = r_mem[2];
  assign p3 = r_mem[3];
  assign p4 = r_mem[4];
  assign p5 = r_mem[5];
  assign p6 = r_mem[6];
  assign p7 = r_mem[7];

endmodule

`default_nettype wire

// File: tb/tb_shift_8_multi_read.sv
// ============================================================================
// Module   : tb_shift_8_multi_read
// Brief    : Scoreboard bench for shift_8_multi_read (either rd_data build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_8_multi_read;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_en = 1'b0;
  logic [6:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data, p2, p3, p4, p5, p6, p7;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [0:7];
  logic [31:0] exp_q [$];

  shift_8_multi_read dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data),
    .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6), .p7(p7)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [6:0] a);
    return (a < 7'd8) ? model[a[2:0]] : 32'h0;
  endfunction

  // One clock cycle with the given controls; model follows the same edge.
  task automatic cycle(input logic rn, input logic we, input logic [31:0] d);
    @(negedge clk);
    rst_n = rn; write_en = we; wr_data = d;
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 8; i++) model[i] = '0;
    end else if (we) begin
      for (int i = 7; i > 0; i--) model[i] = model[i-1];
      model[0] = d;
    end
    #1;
  endtask

  // Read holds storage so combinational and registered builds agree after the edge.
  task automatic read_chk(input string tag, input logic [6:0] a);
    logic [31:0] exp;
    @(negedge clk);
    write_en = 1'b0; addr = a;
    exp_q.push_back(exp_rd(a));
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check($sformatf("%s_rd%0d", tag, a), rd_data, exp);
  endtask

  task automatic chk_taps(input string tag);
    check({tag, "_p2"}, p2, model[2]);
    check({tag, "_p3"}, p3, model[3]);
    check({tag, "_p4"}, p4, model[4]);
    check({tag, "_p5"}, p5, model[5]);
    check({tag, "_p6"}, p6, model[6]);
    check({tag, "_p7"}, p7, model[7]);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset with write_en asserted must not load anything.
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1, 32'hFFFF_FFFF);
    chk_taps("rst");
    for (int a = 0; a < 8; a++) read_chk("rst", 7'(a));

    // Fill with 1..8.
    for (int k = 1; k <= 8; k++) cycle(1'b1, 1'b1, 32'(k));
    check("fill_p2", p2, 32'd6);
    check("fill_p3", p3, 32'd5);
    check("fill_p4", p4, 32'd4);
    check("fill_p5", p5, 32'd3);
    check("fill_p6", p6, 32'd2);
    check("fill_p7", p7, 32'd1);
    for (int a = 0; a < 8; a++) begin
      exp_q.push_back(32'(8 - a));
      read_chk("fill", 7'(a));
      check($sformatf("fill_const%0d", a), rd_data, exp_q.pop_front());
    end

    // Overflow: words 1 and 2 fall off the end.
    cycle(1'b1, 1'b1, 32'd9);
    cycle(1'b1, 1'b1, 32'd10);
    check("ovf_p7", p7, 32'd3);
    check("ovf_p2", p2, 32'd8);
    read_chk("ovf", 7'd0);
    check("ovf_rd0_const", rd_data, 32'd10);

    // Hold with wr_data toggling.
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, $urandom);
    chk_taps("hold");
    for (int a = 0; a < 8; a++) read_chk("hold", 7'(a));

    // Out-of-range addresses read zero and leave storage alone.
    read_chk("oor", 7'd8);
    read_chk("oor", 7'd9);
    read_chk("oor", 7'd64);
    read_chk("oor", 7'd127);
    chk_taps("oor");
    read_chk("oor_after", 7'd0);

    // Full-width data passes unmodified.
    cycle(1'b1, 1'b1, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b1, 32'h8000_0001);
    for (int a = 0; a < 8; a++) read_chk("wide", 7'(a));
    chk_taps("wide");

    // Mid-stream reset pulse.
    cycle(1'b1, 1'b1, 32'hA5);
    cycle(1'b0, 1'b1, 32'h5A);
    chk_taps("mrst");
    read_chk("mrst", 7'd0);
    cycle(1'b1, 1'b1, 32'h5A);
    read_chk("post", 7'd0);
    check("post_rd0_const", rd_data, 32'h5A);
    read_chk("post", 7'd1);
    check("post_rd1_const", rd_data, 32'h0);
    chk_taps("post");

    // Back-to-back writes, then taps must hold the last pattern.
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b1, $urandom);
    chk_taps("b2b");
    for (int a = 0; a < 8; a++) read_chk("b2b", 7'(a));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
